// File: rtl/multi_debouncer.sv
// rtl/multi_debouncer.sv - per-channel button synchroniser, stable-time filter, edge pulses and hold-to-repeat
module multi_debouncer #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 20,
  parameter int STABLE_CNT = 500000,
  parameter int REPEAT_EN  = 1,
  parameter int REP_DELAY  = 25000000,
  parameter int REP_RATE   = 5000000
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [N_CH-1:0] pb_in,
  output logic [N_CH-1:0] pb_out,
  output logic [N_CH-1:0] pb_rise,
  output logic [N_CH-1:0] pb_fall,
  output logic [N_CH-1:0] pb_rep
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DELAY  = 2'd1;
  localparam logic [1:0] REPEAT = 2'd2;

  localparam bit             REP_ON      = (REPEAT_EN != 0);
  localparam longint         MAX_CNT     = (longint'(1) << CNT_W) - 1;
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REP_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST   = CNT_W'(REP_RATE - 1);

  if (STABLE_CNT < 1 || REP_DELAY < 1 || REP_RATE < 1 ||
      longint'(STABLE_CNT) > MAX_CNT || longint'(REP_DELAY) > MAX_CNT ||
      longint'(REP_RATE) > MAX_CNT) begin : g_param_check
    $error("multi_debouncer: timing parameter out of range for CNT_W");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             s0, s1;
    logic             out_q, rise_q, fall_q, rep_q;
    logic [CNT_W-1:0] cnt, rcnt;
    logic [1:0]       state;
    logic             accept, acc_rise, acc_fall, rep_hit;

    // A level is taken only after STABLE_CNT consecutive differing samples.
    assign accept   = (s1 != out_q) && (cnt == STABLE_LAST);
    assign acc_rise = accept && s1;
    assign acc_fall = accept && !s1;

    always_comb begin
      rep_hit = 1'b0;
      case (state)
        DELAY:   rep_hit = (rcnt == DELAY_LAST) && !acc_fall;
        REPEAT:  rep_hit = (rcnt == RATE_LAST) && !acc_fall;
        default: rep_hit = 1'b0;
      endcase
    end

    always_ff @(posedge Clk) begin
      if (Reset) begin
        s0     <= 1'b0;
        s1     <= 1'b0;
        cnt    <= '0;
        out_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        rep_q  <= 1'b0;
      end else begin
        s0     <= pb_in[i];
        s1     <= s0;
        rise_q <= acc_rise;
        fall_q <= acc_fall;
        rep_q  <= acc_rise || rep_hit;
        if (s1 == out_q || accept) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + ONE;
        end
        if (accept) begin
          out_q <= s1;
        end
      end
    end

    always_ff @(posedge Clk) begin
      if (Reset) begin
        state <= IDLE;
        rcnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            rcnt <= '0;
            if (REP_ON && acc_rise) state <= DELAY;
          end
          DELAY: begin
            if (acc_fall) begin
              state <= IDLE;
              rcnt  <= '0;
            end else if (rcnt == DELAY_LAST) begin
              state <= REPEAT;
              rcnt  <= '0;
            end else begin
              rcnt <= rcnt + ONE;
            end
          end
          REPEAT: begin
            if (acc_fall) begin
              state <= IDLE;
              rcnt  <= '0;
            end else if (rcnt == RATE_LAST) begin
              rcnt <= '0;
            end else begin
              rcnt <= rcnt + ONE;
            end
          end
          default: begin
            state <= IDLE;
            rcnt  <= '0;
          end
        endcase
      end
    end

    assign pb_out[i]  = out_q;
    assign pb_rise[i] = rise_q;
    assign pb_fall[i] = fall_q;
    assign pb_rep[i]  = rep_q;
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// tb/tb_multi_debouncer.sv - bench for multi_debouncer with and without auto-repeat
module tb_multi_debouncer;

  localparam int SC = 4;
  localparam int RD = 8;
  localparam int RR = 3;
  localparam int HN = 4096;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [1:0] pb_in = 2'b00;
  logic [1:0] out_a, rise_a, fall_a, rep_a;
  logic [1:0] out_b, rise_b, fall_b, rep_b;

  always #5 Clk = ~Clk;

  multi_debouncer #(.N_CH(2), .CNT_W(8), .STABLE_CNT(SC), .REPEAT_EN(1),
                    .REP_DELAY(RD), .REP_RATE(RR)) dut (
    .Clk(Clk), .Reset(Reset), .pb_in(pb_in),
    .pb_out(out_a), .pb_rise(rise_a), .pb_fall(fall_a), .pb_rep(rep_a));

  multi_debouncer #(.N_CH(2), .CNT_W(8), .STABLE_CNT(SC), .REPEAT_EN(0),
                    .REP_DELAY(RD), .REP_RATE(RR)) dut_nr (
    .Clk(Clk), .Reset(Reset), .pb_in(pb_in),
    .pb_out(out_b), .pb_rise(rise_b), .pb_fall(fall_b), .pb_rep(rep_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a level is accepted once the last SC synchronised samples (all taken
  // after the previous change or reset) disagree with the current output.
  bit         s0v   [2][HN];
  bit         syncv [2][HN];
  bit         m_out [2][2];
  int         m_last[2][2];
  int         m_rise[2][2];
  logic [1:0] e_out [2];
  logic [1:0] e_rise[2];
  logic [1:0] e_fall[2];
  logic [1:0] e_rep [2];
  int         k = 0;
  bit         started = 1'b0;

  initial begin : compare
    logic       r;
    logic [1:0] v;
    bit         flip, nv;
    forever begin
      @(posedge Clk);
      r = Reset;
      v = pb_in;
      #1;
      k++;
      for (int c = 0; c < 2; c++) begin
        if (r) begin
          s0v[c][k]   = 1'b0;
          syncv[c][k] = 1'b0;
        end else begin
          s0v[c][k]   = v[c];
          syncv[c][k] = s0v[c][k-1];
        end
        for (int n = 0; n < 2; n++) begin
          if (r) begin
            started      = 1'b1;
            m_out[n][c]  = 1'b0;
            m_last[n][c] = k;
            m_rise[n][c] = -1000;
            e_out[n][c]  = 1'b0;
            e_rise[n][c] = 1'b0;
            e_fall[n][c] = 1'b0;
            e_rep[n][c]  = 1'b0;
          end else begin
            flip = (k - SC >= m_last[n][c]);
            if (flip)
              for (int j = 1; j <= SC; j++)
                if (syncv[c][k-j] == m_out[n][c]) flip = 1'b0;
            nv = flip ? !m_out[n][c] : m_out[n][c];
            e_rise[n][c] = flip && nv;
            e_fall[n][c] = flip && !nv;
            if (flip) m_last[n][c] = k;
            if (flip && nv) m_rise[n][c] = k;
            e_rep[n][c] = e_rise[n][c] ||
                          ((n == 0) && nv && (k - m_rise[n][c] >= RD) &&
                           ((k - m_rise[n][c] - RD) % RR == 0));
            m_out[n][c] = nv;
            e_out[n][c] = nv;
          end
        end
      end
      if (started) begin
        chk("model_out_a", out_a, e_out[0]);
        chk("model_rise_a", rise_a, e_rise[0]);
        chk("model_fall_a", fall_a, e_fall[0]);
        chk("model_rep_a", rep_a, e_rep[0]);
        chk("model_out_b", out_b, e_out[1]);
        chk("model_rise_b", rise_b, e_rise[1]);
        chk("model_fall_b", fall_b, e_fall[1]);
        chk("model_rep_b", rep_b, e_rep[1]);
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge Clk);
  endtask

  int runs[20] = '{1, 2, 3, 1, 3, 2, 2, 1, 3, 2, 1, 3, 2, 3, 1, 2, 3, 1, 2, 2};

  initial begin : stim
    logic [1:0] exp_rep;

    // Reset held two cycles with both buttons pressed
    pb_in = 2'b11;
    Reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_n(1);
      chk("rst_out", out_a, 2'b00);
      chk("rst_rise", rise_a, 2'b00);
      chk("rst_rep", rep_a, 2'b00);
    end
    Reset = 1'b0;
    wait_n(5);
    chk("rst_out_e5", out_a, 2'b00);
    wait_n(1);
    chk("rst_out_e6", out_a, 2'b11);
    chk("both_rise", rise_a, 2'b11);
    chk("nr_same_edge", out_b, 2'b11);
    chk("nr_rep_eq_rise", rep_b, 2'b11);
    wait_n(RD);
    chk("rep_both_r8", rep_a, 2'b11);
    chk("nr_no_repeat", rep_b, 2'b00);
    pb_in = 2'b00;
    wait_n(6);
    chk("both_fall", fall_a, 2'b11);
    chk("both_fall_nr", fall_b, 2'b11);
    wait_n(10);

    // Clean press and release on ch0
    pb_in = 2'b01;
    wait_n(5);
    chk("press_e5", out_a, 2'b00);
    wait_n(1);
    chk("press_e6", out_a, 2'b01);
    chk("press_rise", rise_a, 2'b01);
    wait_n(1);
    chk("press_rise_gone", rise_a, 2'b00);
    pb_in = 2'b00;
    wait_n(5);
    chk("rel_e5", out_a, 2'b01);
    wait_n(1);
    chk("rel_e6", out_a, 2'b00);
    chk("rel_fall", fall_a, 2'b01);
    wait_n(1);
    chk("rel_fall_gone", fall_a, 2'b00);
    wait_n(5);

    // Bounce: runs of 1-3 cycles, ending low
    for (int i = 0; i < 20; i++) begin
      pb_in[0] = (i % 2 == 0);
      wait_n(runs[i]);
    end
    chk("bounce_out", out_a, 2'b00);
    pb_in[0] = 1'b1;
    wait_n(5);
    chk("bounce_hold_e5", out_a, 2'b00);
    wait_n(1);
    chk("bounce_hold_e6", out_a, 2'b01);
    chk("bounce_hold_rise", rise_a, 2'b01);
    pb_in = 2'b00;
    wait_n(10);

    // Auto-repeat on ch1
    pb_in = 2'b10;
    wait_n(6);
    chk("rep_r0", rep_a, 2'b10);
    for (int off = 1; off <= 15; off++) begin
      wait_n(1);
      exp_rep = (off == 8 || off == 11 || off == 14) ? 2'b10 : 2'b00;
      chk($sformatf("rep_r%0d", off), rep_a, exp_rep);
    end
    pb_in = 2'b00;
    wait_n(6);
    chk("rep_fall", fall_a, 2'b10);
    chk("rep_none_at_fall", rep_a, 2'b00);
    wait_n(20);

    // Reset while the filter count is at 2
    pb_in = 2'b01;
    wait_n(4);
    Reset = 1'b1;
    wait_n(1);
    chk("midcnt_rst_out", out_a, 2'b00);
    chk("midcnt_rst_rise", rise_a, 2'b00);
    Reset = 1'b0;
    wait_n(5);
    chk("midcnt_e5", out_a, 2'b00);
    wait_n(1);
    chk("midcnt_e6", out_a, 2'b01);
    pb_in = 2'b00;
    wait_n(10);

    // Reset while in REPEAT
    pb_in = 2'b10;
    wait_n(6 + 10);
    Reset = 1'b1;
    wait_n(1);
    chk("rep_rst_out", out_a, 2'b00);
    chk("rep_rst_rep", rep_a, 2'b00);
    chk("rep_rst_fall", fall_a, 2'b00);
    Reset = 1'b0;
    wait_n(5);
    chk("rep_rst_e5", out_a, 2'b00);
    wait_n(1);
    chk("rep_rst_e6", out_a, 2'b10);
    chk("rep_rst_rep_e6", rep_a, 2'b10);
    wait_n(RD);
    chk("rep_rst_r8", rep_a, 2'b10);
    pb_in = 2'b00;
    wait_n(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
